// File: rtl/sram_io_host_pkg.sv
// sram_io_host_pkg: shared encodings and default widths for the SRAM serial I/O host.
// Contents: CTRL phase codes, FSM state and phase enums, default widths, and helpers
// that map a phase to its CTRL code and tell whether the phase shifts a frame.
package sram_io_host_pkg;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_TIMEOUT = 64;
   localparam logic [1:0] CTRL_SHIFT = 2'b00;
   localparam logic [1:0] CTRL_RD    = 2'b01;
   localparam logic [1:0] CTRL_WR    = 2'b11;
   typedef enum logic [2:0] {ST_IDLE, ST_BGNL, ST_CMD, ST_GAP, ST_SHIFT, ST_WAIT, ST_FIN} state_t;
   typedef enum logic [1:0] {PH_S, PH_W, PH_R, PH_D} phase_t;
   function automatic logic [1:0] phase_code(input phase_t p);
      return (p == PH_W) ? CTRL_WR : (p == PH_R) ? CTRL_RD : CTRL_SHIFT;
   endfunction
   function automatic logic phase_shifts(input phase_t p);
      return (p == PH_S) || (p == PH_D);
   endfunction
endpackage

// File: rtl/sram_io_host_shreg.sv
// sram_io_host_shreg: parallel-load, LSB-first shifter with a saturating bit counter.
// Ports: CLK/RST (sync, active high); load captures din and clears the counter;
// shift moves the register right by one; bit_out is the current LSB;
// cnt is the number of shifts since load; tc flags cnt == W-1.
module sram_io_host_shreg
#(
   parameter int W = 18
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 load,
   input  logic [W-1:0]         din,
   input  logic                 shift,
   output logic                 bit_out,
   output logic [$clog2(W)-1:0] cnt,
   output logic                 tc
);
   localparam int CW = $clog2(W);
   logic [W-1:0] sr;
   always_ff @(posedge CLK) begin
      if (RST) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= din;
         cnt <= '0;
      end else if (shift) begin
         sr  <= sr >> 1;
         cnt <= tc ? cnt : cnt + 1'b1;
      end
   end
   assign bit_out = sr[0];
   assign tc      = cnt == CW'(W - 1);
endmodule

// File: rtl/sram_io_host.sv
// sram_io_host: host-side serial master that runs write/read transactions on the SRAM serial link.
// Request side: REQ/WR/ADDR/WDATA in, BUSY/DONE/RDATA out.
// Link side: BGN, LOAD_N, CTRL, SI out; RDY, SO in. CLK is shared with the link; RST is sync, active high.
// Optional: define SRAM_IO_HOST_TIMEOUT_EN to add the RDY watchdog and the ERR output.
module sram_io_host
   import sram_io_host_pkg::*;
#(
   parameter int MEMORY_DATA_WIDTH = DEF_DATA_W,
   parameter int MEMORY_ADDR_WIDTH = DEF_ADDR_W,
   parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         REQ,
   input  logic                         WR,
   input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR,
   input  logic [MEMORY_DATA_WIDTH-1:0] WDATA,
   output logic                         BUSY,
   output logic                         DONE,
   output logic [MEMORY_DATA_WIDTH-1:0] RDATA,
`ifdef SRAM_IO_HOST_TIMEOUT_EN
   output logic                         ERR,
`endif
   output logic                         BGN,
   output logic                         LOAD_N,
   output logic [1:0]                   CTRL,
   output logic                         SI,
   input  logic                         RDY,
   input  logic                         SO
);
   localparam int DW = MEMORY_DATA_WIDTH;
   localparam int RW = REG_BITS_WIDTH;
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
   state_t                         state, state_nx;
   phase_t                         phase, phase_nx;
   logic                           wr_q;
   logic [MEMORY_ADDR_WIDTH-1:0]   addr_q;
   logic [DW-1:0]                  wdata_q, rd_buf;
   logic                           sh_bit, sh_tc;
   logic [$clog2(RW)-1:0]          sh_cnt;
   logic                           timeout, to_q;
   // Only a write's first phase carries data; the read's phases send zeros with the address.
   sram_io_host_shreg #(.W(RW)) u_shreg (
      .CLK     (CLK),
      .RST     (RST),
      .load    (state == ST_CMD),
      .din     (RW'({addr_q, (phase == PH_S && wr_q) ? wdata_q : {DW{1'b0}}})),
      .shift   (state == ST_SHIFT),
      .bit_out (sh_bit),
      .cnt     (sh_cnt),
      .tc      (sh_tc)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         phase   <= PH_S;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_buf  <= '0;
         RDATA   <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         if (state == ST_IDLE && REQ) begin
            wr_q    <= WR;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
         end
         // SO shows the bit about to leave the controller, so sampling before each shift gathers DATA LSB first.
         if (state == ST_SHIFT && phase == PH_D && int'(sh_cnt) < DW)
            rd_buf <= {SO, rd_buf[DW-1:1]};
         if (state == ST_WAIT && RDY && phase == PH_D)
            RDATA <= rd_buf;
      end
   end
`ifdef SRAM_IO_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] wait_cnt;
   // The counter sits at zero outside WAIT, so it is already clear on every WAIT entry.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt <= '0;
         to_q     <= 1'b0;
      end else begin
         wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         to_q     <= timeout;
      end
   end
   assign timeout = state == ST_WAIT && !RDY && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign ERR     = to_q;
`else
   assign timeout = 1'b0;
   assign to_q    = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      phase_nx = phase;
      case (state)
         ST_IDLE:  if (REQ) begin
                      state_nx = ST_BGNL;
                      phase_nx = PH_S;
                   end
         ST_BGNL:  state_nx = ST_CMD;
         ST_CMD:   state_nx = ST_GAP;
         ST_GAP:   state_nx = phase_shifts(phase) ? ST_SHIFT : ST_WAIT;
         ST_SHIFT: state_nx = sh_tc ? ST_WAIT : ST_SHIFT;
         ST_WAIT:  if (RDY) begin
                      state_nx = (phase == PH_W || phase == PH_D) ? ST_FIN : ST_BGNL;
                      phase_nx = (phase == PH_S) ? (wr_q ? PH_W : PH_R) : (phase == PH_R) ? PH_D : phase;
                   end else if (timeout) begin
                      state_nx = ST_FIN;
                   end
         ST_FIN:   state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end
   assign BUSY   = state != ST_IDLE && state != ST_FIN;
   assign DONE   = state == ST_FIN;
   assign BGN    = (state == ST_FIN) ? !to_q : (state != ST_IDLE && state != ST_BGNL);
   assign LOAD_N = state != ST_CMD;
   assign CTRL   = (state inside {ST_CMD, ST_GAP, ST_SHIFT, ST_WAIT}) ? phase_code(phase) : CTRL_SHIFT;
   assign SI     = state == ST_SHIFT && sh_bit;
endmodule
